// File: rtl/lock_pkg.sv
// Shared encodings and constants for the combo-lock keypad controller and lock FSM.
package lock_pkg;

   localparam int unsigned DEF_DIGITS = 4;
   localparam int unsigned CODE_W     = 4 * DEF_DIGITS;

   // Lock FSM output encodings (2'b11 is treated as L)
   localparam logic [1:0] LS_L = 2'b00;
   localparam logic [1:0] LS_U = 2'b01;
   localparam logic [1:0] LS_H = 2'b10;

   // Keypad controller states
   localparam logic [1:0] ST_IDLE     = 2'b00;
   localparam logic [1:0] ST_ENTRY    = 2'b01;
   localparam logic [1:0] ST_SUBMIT   = 2'b10;
   localparam logic [1:0] ST_COOLDOWN = 2'b11;

   localparam logic [CODE_W-1:0] BANK_CODE     = 16'hAAAA;
   localparam logic [CODE_W-1:0] OVERRIDE_CODE = 16'hFFFF;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable saturating down-counter; done flags a zero count.
module lock_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         enable,
   output logic         done
);

   logic [W-1:0] count;
   logic [W-1:0] count_n;

   // Load wins over enable; the count stops at zero instead of wrapping
   always_comb begin
      count_n = count;
      if (load)
         count_n = load_val;
      else if (enable && (count != '0))
         count_n = count - W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
         done  <= 1'b1;
      end else begin
         count <= count_n;
         done  <= (count_n == '0);
      end
   end

endmodule

// File: rtl/code_entry_ctrl.sv
// Keypad-side sequencer: buffers hex digits, submits codes to the lock FSM,
// enforces the partial-entry timeout and the post-lockout cooldown.
module code_entry_ctrl
   import lock_pkg::*;
#(
   parameter int unsigned DIGITS      = DEF_DIGITS,
   parameter int unsigned TIMEOUT_CYC = 1000,
   parameter int unsigned LOCKOUT_CYC = 5000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                press,
   input  logic [3:0]          key,
   input  logic                enter,
   input  logic                clear,
   input  logic [1:0]          lock_state,
   output logic [4*DIGITS-1:0] code_out,
   output logic                code_valid,
   output logic [2:0]          digit_count,
   output logic                entry_err,
   output logic                busy
);

   localparam int unsigned ENTRY_W = 4 * DIGITS;
   localparam int unsigned CNT_W   = $clog2(max_u(TIMEOUT_CYC, LOCKOUT_CYC) + 1);
   // Timers are loaded one short so the event lands on the Nth cycle
   localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(LOCKOUT_CYC - 1);
   localparam logic [2:0]       FULL    = 3'(DIGITS);

   logic [1:0]         state, state_n;
   logic [ENTRY_W-1:0] buffer, buffer_n;
   logic [ENTRY_W-1:0] code_n;
   logic [2:0]         count_n;
   logic               valid_n, err_n, busy_n;
   logic [1:0]         ls_q;
   logic               lock_hit;
   logic               to_load, to_en, to_done;
   logic               cd_load, cd_en, cd_done;

   lock_timer #(.W(CNT_W)) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .load     (to_load),
      .load_val (TO_LOAD),
      .enable   (to_en),
      .done     (to_done)
   );

   lock_timer #(.W(CNT_W)) u_cooldown (
      .clk      (clk),
      .reset    (reset),
      .load     (cd_load),
      .load_val (CD_LOAD),
      .enable   (cd_en),
      .done     (cd_done)
   );

   // Only a fresh edge into H starts a cooldown; staying in H does not
   assign lock_hit = (lock_state == LS_H) && (ls_q != LS_H);

   always_comb begin
      state_n  = state;
      buffer_n = buffer;
      count_n  = digit_count;
      code_n   = code_out;
      valid_n  = 1'b0;
      err_n    = 1'b0;
      busy_n   = 1'b0;
      to_load  = 1'b0;
      to_en    = 1'b0;
      cd_load  = 1'b0;
      cd_en    = 1'b0;

      case (state)
         ST_IDLE: begin
            if (clear) begin
               state_n = ST_IDLE;
            end else if (enter) begin
               err_n = 1'b1;
            end else if (press) begin
               buffer_n = ENTRY_W'(key);
               count_n  = 3'd1;
               to_load  = 1'b1;
               state_n  = ST_ENTRY;
            end
         end
         ST_ENTRY: begin
            if (clear) begin
               buffer_n = '0;
               count_n  = 3'd0;
               state_n  = ST_IDLE;
            end else if (enter) begin
               if (digit_count == FULL) begin
                  state_n = ST_SUBMIT;
               end else begin
                  err_n    = 1'b1;
                  buffer_n = '0;
                  count_n  = 3'd0;
                  state_n  = ST_IDLE;
               end
            end else if (press) begin
               to_load = 1'b1;
               if (digit_count < FULL) begin
                  buffer_n = {buffer[ENTRY_W-5:0], key};
                  count_n  = digit_count + 3'd1;
               end else begin
                  err_n = 1'b1;
               end
            end else begin
               to_en = 1'b1;
               if (to_done) begin
                  err_n    = 1'b1;
                  buffer_n = '0;
                  count_n  = 3'd0;
                  state_n  = ST_IDLE;
               end
            end
         end
         ST_SUBMIT: begin
            code_n   = buffer;
            valid_n  = 1'b1;
            buffer_n = '0;
            count_n  = 3'd0;
            state_n  = ST_IDLE;
         end
         default: begin
            busy_n = 1'b1;
            cd_en  = 1'b1;
            if (cd_done) begin
               busy_n  = 1'b0;
               state_n = ST_IDLE;
            end
         end
      endcase

      // Lockout overrides everything except a submit already in flight
      if (lock_hit) begin
         state_n  = ST_COOLDOWN;
         busy_n   = 1'b1;
         cd_load  = 1'b1;
         cd_en    = 1'b0;
         to_load  = 1'b0;
         to_en    = 1'b0;
         err_n    = 1'b0;
         buffer_n = '0;
         count_n  = 3'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         buffer      <= '0;
         ls_q        <= LS_L;
         code_out    <= '0;
         code_valid  <= 1'b0;
         digit_count <= 3'd0;
         entry_err   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         buffer      <= buffer_n;
         ls_q        <= lock_state;
         code_out    <= code_n;
         code_valid  <= valid_n;
         digit_count <= count_n;
         entry_err   <= err_n;
         busy        <= busy_n;
      end
   end

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Directed bench for code_entry_ctrl: vector table plus timeout/lockout/reset sequences.
module tb_code_entry_ctrl;

   localparam logic [1:0] L = 2'b00;
   localparam logic [1:0] H = 2'b10;

   logic        clk = 1'b0;
   logic        reset;
   logic        press;
   logic [3:0]  key;
   logic        enter;
   logic        clear;
   logic [1:0]  lock_state;
   logic [15:0] code_out;
   logic        code_valid;
   logic [2:0]  digit_count;
   logic        entry_err;
   logic        busy;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic        press;
      logic [3:0]  key;
      logic        enter;
      logic        clear;
      logic        ev;
      logic        ee;
      logic [2:0]  ec;
      logic [15:0] eco;
   } vec_t;

   vec_t tbl[$];

   code_entry_ctrl #(
      .DIGITS      (4),
      .TIMEOUT_CYC (16),
      .LOCKOUT_CYC (32)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .press       (press),
      .key         (key),
      .enter       (enter),
      .clear       (clear),
      .lock_state  (lock_state),
      .code_out    (code_out),
      .code_valid  (code_valid),
      .digit_count (digit_count),
      .entry_err   (entry_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic p, input logic [3:0] k, input logic e, input logic c,
                               input logic ev, input logic ee, input logic [2:0] ec,
                               input logic [15:0] eco);
      vec_t v;
      v.press = p; v.key = k; v.enter = e; v.clear = c;
      v.ev = ev; v.ee = ee; v.ec = ec; v.eco = eco;
      return v;
   endfunction

   // One clock: drive on the falling edge, check just after the rising edge
   task automatic step(input string nm, input logic rs, input logic p, input logic [3:0] k,
                       input logic e, input logic c, input logic [1:0] ls,
                       input logic ev, input logic ee, input logic [2:0] ec, input logic eb,
                       input logic [15:0] eco);
      @(negedge clk);
      reset = rs; press = p; key = k; enter = e; clear = c; lock_state = ls;
      @(posedge clk);
      #1;
      tests++;
      if ({code_valid, entry_err, digit_count, busy, code_out} !== {ev, ee, ec, eb, eco}) begin
         failed++;
         $display("FAIL %s: got valid=%0b err=%0b cnt=%0d busy=%0b code=%h, want valid=%0b err=%0b cnt=%0d busy=%0b code=%h",
                  nm, code_valid, entry_err, digit_count, busy, code_out, ev, ee, ec, eb, eco);
      end
   endtask

   initial begin
      reset = 1'b0; press = 1'b0; key = 4'h0; enter = 1'b0; clear = 1'b0; lock_state = L;

      step("reset0", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, L, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000);
      step("reset1", 1'b0, 1'b1, 4'h5, 1'b1, 1'b0, L, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000);

      // AAAA submit
      tbl.push_back(mk(1, 4'hA, 0, 0, 0, 0, 3'd1, 16'h0000));
      tbl.push_back(mk(1, 4'hA, 0, 0, 0, 0, 3'd2, 16'h0000));
      tbl.push_back(mk(1, 4'hA, 0, 0, 0, 0, 3'd3, 16'h0000));
      tbl.push_back(mk(1, 4'hA, 0, 0, 0, 0, 3'd4, 16'h0000));
      tbl.push_back(mk(0, 4'h0, 1, 0, 0, 0, 3'd4, 16'h0000));
      tbl.push_back(mk(0, 4'h0, 0, 0, 1, 0, 3'd0, 16'hAAAA));
      tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 3'd0, 16'hAAAA));
      // short entry then enter
      tbl.push_back(mk(1, 4'h1, 0, 0, 0, 0, 3'd1, 16'hAAAA));
      tbl.push_back(mk(1, 4'h2, 0, 0, 0, 0, 3'd2, 16'hAAAA));
      tbl.push_back(mk(0, 4'h0, 1, 0, 0, 1, 3'd0, 16'hAAAA));
      tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 3'd0, 16'hAAAA));
      // idle enter rejected
      tbl.push_back(mk(0, 4'h0, 1, 0, 0, 1, 3'd0, 16'hAAAA));
      // overfull entry then submit 1234
      tbl.push_back(mk(1, 4'h1, 0, 0, 0, 0, 3'd1, 16'hAAAA));
      tbl.push_back(mk(1, 4'h2, 0, 0, 0, 0, 3'd2, 16'hAAAA));
      tbl.push_back(mk(1, 4'h3, 0, 0, 0, 0, 3'd3, 16'hAAAA));
      tbl.push_back(mk(1, 4'h4, 0, 0, 0, 0, 3'd4, 16'hAAAA));
      tbl.push_back(mk(1, 4'h5, 0, 0, 0, 1, 3'd4, 16'hAAAA));
      tbl.push_back(mk(0, 4'h0, 1, 0, 0, 0, 3'd4, 16'hAAAA));
      tbl.push_back(mk(0, 4'h0, 0, 0, 1, 0, 3'd0, 16'h1234));
      tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 3'd0, 16'h1234));
      // clear beats enter mid-entry
      tbl.push_back(mk(1, 4'h9, 0, 0, 0, 0, 3'd1, 16'h1234));
      tbl.push_back(mk(0, 4'h0, 1, 1, 0, 0, 3'd0, 16'h1234));
      tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 3'd0, 16'h1234));

      for (int i = 0; i < tbl.size(); i++)
         step($sformatf("vec%0d", i), 1'b1, tbl[i].press, tbl[i].key, tbl[i].enter, tbl[i].clear, L,
              tbl[i].ev, tbl[i].ee, tbl[i].ec, 1'b0, tbl[i].eco);

      // Timeout: error on the 16th idle cycle after the last press
      step("to_press", 1'b1, 1'b1, 4'h7, 1'b0, 1'b0, L, 1'b0, 1'b0, 3'd1, 1'b0, 16'h1234);
      for (int i = 1; i <= 17; i++)
         step($sformatf("to_idle%0d", i), 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, L,
              1'b0, (i == 16), (i >= 16) ? 3'd0 : 3'd1, 1'b0, 16'h1234);
      step("to_enter", 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, L, 1'b0, 1'b1, 3'd0, 1'b0, 16'h1234);

      // Lockout mid-entry: 32 busy cycles, keypad ignored, then override code
      step("lk_p1", 1'b1, 1'b1, 4'h1, 1'b0, 1'b0, L, 1'b0, 1'b0, 3'd1, 1'b0, 16'h1234);
      step("lk_p2", 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, L, 1'b0, 1'b0, 3'd2, 1'b0, 16'h1234);
      step("lk_hit", 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, H, 1'b0, 1'b0, 3'd0, 1'b1, 16'h1234);
      for (int i = 1; i <= 31; i++)
         step($sformatf("lk_busy%0d", i), 1'b1, 1'b1, 4'(i), (i == 5), (i == 9), H,
              1'b0, 1'b0, 3'd0, 1'b1, 16'h1234);
      step("lk_end", 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, H, 1'b0, 1'b0, 3'd0, 1'b0, 16'h1234);
      for (int i = 1; i <= 4; i++)
         step($sformatf("ov_p%0d", i), 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, H,
              1'b0, 1'b0, 3'(i), 1'b0, 16'h1234);
      step("ov_enter", 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, H, 1'b0, 1'b0, 3'd4, 1'b0, 16'h1234);
      step("ov_sub", 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, H, 1'b1, 1'b0, 3'd0, 1'b0, 16'hFFFF);
      step("ov_hold", 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, L, 1'b0, 1'b0, 3'd0, 1'b0, 16'hFFFF);

      // Reset mid-entry, then press+clear together
      step("rs_p1", 1'b1, 1'b1, 4'h1, 1'b0, 1'b0, L, 1'b0, 1'b0, 3'd1, 1'b0, 16'hFFFF);
      step("rs_p2", 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, L, 1'b0, 1'b0, 3'd2, 1'b0, 16'hFFFF);
      step("rs_p3", 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, L, 1'b0, 1'b0, 3'd3, 1'b0, 16'hFFFF);
      step("rs_assert", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, L, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000);
      step("rs_pc", 1'b1, 1'b1, 4'h6, 1'b0, 1'b1, L, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000);
      step("rs_after", 1'b1, 1'b1, 4'h6, 1'b0, 1'b0, L, 1'b0, 1'b0, 3'd1, 1'b0, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/code_entry_ctrl.md
Name: code_entry_ctrl

Overview:
Keypad-side sequencer for the combo-lock FSM. It collects debounced hex key presses into a 16-bit code and presents it to the lock FSM's code input only at defined submit instants, with a one-cycle valid strobe. It also enforces an inactivity timeout on partial entries and a post-lockout cooldown. It sits between the keypad debouncer and the lock FSM, and reads back the FSM's lock output.

Parameters:
DIGITS, 4, hex digits per code; code width = 4*DIGITS.
TIMEOUT_CYC, 1000, idle cycles in ENTRY before a partial entry is discarded.
LOCKOUT_CYC, 5000, cycles of ignored keypad input after lock_state enters H.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-low reset.
press  in  1  one-cycle strobe: key holds a valid digit.
key  in  4  hex digit value, qualified by press.
enter  in  1  one-cycle strobe: submit the buffered code.
clear  in  1  one-cycle strobe: discard the buffer.
lock_state  in  2  lock FSM output: 00=L (locked), 01=U (unlocked), 10=H (lockout), 11 treated as L.
code_out  out  4*DIGITS  registered code driven to the lock FSM input.
code_valid  out  1  one-cycle pulse in the cycle code_out takes a new value.
digit_count  out  3  digits currently buffered (0..DIGITS).
entry_err  out  1  one-cycle pulse on a rejected action.
busy  out  1  high in COOLDOWN (keypad ignored).

Behaviour:
- Reset (reset==0 at a clk edge) takes priority over everything. All outputs go to 0, buffer = 0, both counters = 0, state = IDLE. Reset mid-entry discards the partial code without raising entry_err.
- States: IDLE, ENTRY, SUBMIT, COOLDOWN.
- Input priority within a cycle: clear > enter > press.
- Digit shift: buffer <= {buffer[4*DIGITS-5:0], key}, so digits enter MSB-first. Each accepted press increments digit_count.
- IDLE:
  - press → capture digit, go to ENTRY, digit_count=1.
  - enter → entry_err pulse, stay in IDLE.
  - clear → no-op.
- ENTRY:
  - press with digit_count<DIGITS → shift digit in, reload the timeout counter.
  - press with digit_count==DIGITS → digit ignored, entry_err pulse, timeout counter reloaded.
  - enter with digit_count==DIGITS → go to SUBMIT.
  - enter with digit_count<DIGITS → entry_err pulse, buffer and count cleared, go to IDLE.
  - clear → buffer and count cleared, go to IDLE, no error.
  - Timeout counter reaches TIMEOUT_CYC with no press → buffer cleared, entry_err pulse, go to IDLE.
- SUBMIT (exactly one cycle):
  - code_out <= buffer, code_valid=1 in that same cycle.
  - Buffer and count cleared; go to IDLE.
  - Keypad strobes arriving in SUBMIT are dropped silently.
- Latency: enter accepted at edge N → code_out/code_valid updated at edge N+1.
- code_out holds its value between submits. It changes only in SUBMIT or on reset. The lock FSM samples continuously, so code_out must never glitch or partially update.
- Lockout detection: lock_state transitioning from any other value to H, sampled registered, forces COOLDOWN from any state.
  - Any partial entry is discarded; a pending SUBMIT completes first.
  - Cooldown counter is loaded with LOCKOUT_CYC.
- COOLDOWN:
  - busy=1; press, enter and clear are ignored with no entry_err.
  - Counter decrements to 0, then state → IDLE and busy=0.
  - If lock_state is still H after cooldown, entry is re-enabled so the override code can be keyed. Remaining in H does not retrigger COOLDOWN; only a new edge into H does.
- Counter widths: $clog2(max(TIMEOUT_CYC,LOCKOUT_CYC)+1). Counters saturate and never wrap.
- entry_err and code_valid are never asserted in the same cycle.

Decomposition:
- Package lock_pkg holds:
  - lock-state encodings L=2'b00, U=2'b01, H=2'b10;
  - the controller state encoding;
  - code-width localparam CODE_W = 4*DIGITS;
  - bank code 16'hAAAA and override code 16'hFFFF, shared with the lock FSM.
- One sub-module, lock_timer: loadable saturating down-counter with load, enable and done (count==0). It is instantiated twice, once for the timeout and once for the cooldown.

Test Plan:
Run the bench with TIMEOUT_CYC=16 and LOCKOUT_CYC=32.
- Reset, then keys A,A,A,A, then enter → one cycle later code_out=16'hAAAA and code_valid=1 for exactly 1 cycle; digit_count returns to 0.
- Keys 1,2 then enter → entry_err pulse; code_out unchanged (still AAAA); state IDLE.
- Keys 1,2,3,4,5 → fifth press raises entry_err; enter then submits 16'h1234.
- Key 7 then 17 idle cycles → entry_err at cycle 16 after the last press; digit_count=0; a following enter raises entry_err.
- Drive lock_state=H mid-entry (2 digits buffered) → busy=1 for 32 cycles; presses during that window are ignored with no entry_err; then keys F,F,F,F plus enter → code_out=16'hFFFF.
- Keys 1,2,3 then reset=0 for 1 cycle → all outputs 0; press and clear asserted in the same cycle → clear wins, digit_count=0.
